vga_line_prefetch: RTL and testbench

Pixel source that sits directly upstream of the VGA timing controller and drives its 24-bit colour input. Per visible line, fetches H_VISIBLE pixels from a frame buffer over a variable-latency read port into a small FIFO, then pops one pixel per clock while the controller's active flag is high. Frame start (the controller's screenend pulse) rewinds the read pointer to the top of the frame.

---
 rtl/vga_line_prefetch.sv | 202 ++++++++++++++++++++
 tb/tb_vga_line_prefetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_prefetch.sv
// vga_line_prefetch
//   Pixel source in front of the VGA timing controller. On each accepted
//   line_start it fetches H_VISIBLE pixels from a frame buffer over a
//   variable-latency read port into a small FIFO, and pops one pixel per
//   clock while the controller's active flag is high. frame_start rewinds
//   the fetch position to the top of the frame and flushes the FIFO.
//
//   Ports:
//     clk, rst           pixel clock, asynchronous active-high reset
//     frame_start        one-cycle new-frame pulse (controller screenend)
//     line_start         one-cycle pulse ahead of each line's active window
//     active             controller visible-pixel flag
//     color_out          registered pixel to the controller colour input
//     mem_req/mem_addr   read request and word address (held until mem_ack)
//     mem_ack            request accepted this cycle
//     mem_rvalid/rdata   in-order read responses, any latency >= 1
//     underflow          sticky error flag (FIFO empty while active, or a
//                        line_start arriving before the previous line was
//                        fully requested)
//     fifo_level         current FIFO occupancy
module vga_line_prefetch #(
  parameter int unsigned       H_VISIBLE       = 1024,
  parameter int unsigned       V_VISIBLE       = 768,
  parameter int unsigned       FIFO_DEPTH      = 16,
  parameter int unsigned       ADDR_W          = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter logic [23:0]       UNDERFLOW_COLOR = 24'hFF00FF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          line_start,
  input  logic                          active,
  output logic [23:0]                   color_out,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  input  logic                          mem_rvalid,
  input  logic [23:0]                   mem_rdata,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(H_VISIBLE + 1);
  localparam int unsigned Y_W   = $clog2(V_VISIBLE + 1);

  localparam logic [LVL_W:0]      DEPTH_W  = (LVL_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    H_CNT    = CNT_W'(H_VISIBLE);
  localparam logic [Y_W-1:0]      V_CNT    = Y_W'(V_VISIBLE);
  localparam logic [ADDR_W-1:0]   H_STRIDE = ADDR_W'(H_VISIBLE);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    fetch_cnt_q, fetch_cnt_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LVL_W-1:0]    out_q, out_d;
  logic [LVL_W-1:0]    disc_q, disc_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [23:0]         color_q, color_d;
  logic                uf_q, uf_d;

  logic [23:0]         fifo_mem [FIFO_DEPTH];

  logic                credit_ok;
  logic                xfer;
  logic                push;
  logic                pop;

  // Outstanding reads are counted against FIFO space, so every response
  // always has a slot waiting for it.
  assign credit_ok = ({1'b0, level_q} + {1'b0, out_q}) < DEPTH_W;
  assign mem_req   = (state_q == FETCH) && (fetch_cnt_q < H_CNT) && credit_ok;
  assign xfer      = mem_req && mem_ack;
  assign pop       = active && (level_q != '0);
  // Responses to reads issued before the last frame_start are dropped.
  assign push      = mem_rvalid && (disc_q == '0) && !frame_start;

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    y_d         = y_q;
    line_addr_d = line_addr_q;
    mem_addr_d  = mem_addr_q;
    out_d       = out_q;
    disc_d      = disc_q;
    level_d     = level_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    color_d     = '0;
    uf_d        = uf_q;

    // Request side
    if (xfer) begin
      mem_addr_d  = mem_addr_q + ADDR_W'(1);
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      if (fetch_cnt_q == H_CNT - CNT_W'(1)) begin
        state_d     = IDLE;
        y_d         = y_q + Y_W'(1);
        line_addr_d = line_addr_q + H_STRIDE;
      end
    end

    // Outstanding-read bookkeeping
    if (xfer && !mem_rvalid) begin
      out_d = out_q + LVL_W'(1);
    end else if (!xfer && mem_rvalid) begin
      out_d = out_q - LVL_W'(1);
    end
    if (mem_rvalid && (disc_q != '0)) begin
      disc_d = disc_q - LVL_W'(1);
    end

    // FIFO push/pop and the registered pixel output
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (active) begin
      if (pop) begin
        color_d  = fifo_mem[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        color_d = UNDERFLOW_COLOR;
        uf_d    = 1'b1;
      end
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push && pop) begin
      level_d = level_q - LVL_W'(1);
    end

    // frame_start overrides everything above except output and counters of
    // reads already on the bus, which become the discard count.
    if (frame_start) begin
      state_d     = IDLE;
      y_d         = '0;
      line_addr_d = BASE_ADDR;
      mem_addr_d  = BASE_ADDR;
      disc_d      = out_d;
      level_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end else if (line_start) begin
      if (state_q == FETCH) begin
        uf_d = 1'b1;
      end else if (y_q < V_CNT) begin
        state_d     = FETCH;
        fetch_cnt_d = '0;
        mem_addr_d  = line_addr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_cnt_q <= '0;
      y_q         <= '0;
      line_addr_q <= BASE_ADDR;
      mem_addr_q  <= BASE_ADDR;
      out_q       <= '0;
      disc_q      <= '0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      color_q     <= '0;
      uf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      y_q         <= y_d;
      line_addr_q <= line_addr_d;
      mem_addr_q  <= mem_addr_d;
      out_q       <= out_d;
      disc_q      <= disc_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      color_q     <= color_d;
      uf_q        <= uf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  assign color_out  = color_q;
  assign mem_addr   = mem_addr_q;
  assign underflow  = uf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_vga_line_prefetch.sv
module tb_vga_line_prefetch;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 2;
  localparam int unsigned D  = 4;
  localparam logic [19:0] BASE = 20'h100;
  localparam logic [23:0] UF_COLOR = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, line_start, active;
  logic [23:0] color_out;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack, mem_rvalid;
  logic [23:0] mem_rdata;
  logic        underflow;
  logic [2:0]  fifo_level;

  vga_line_prefetch #(
    .H_VISIBLE(H), .V_VISIBLE(V), .FIFO_DEPTH(D), .ADDR_W(20),
    .BASE_ADDR(BASE), .UNDERFLOW_COLOR(UF_COLOR)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .active(active), .color_out(color_out), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .underflow(underflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Memory + behavioural model state
  typedef struct {logic [19:0] addr; int due; int gen;} req_t;
  req_t        pend[$];
  logic [23:0] mfifo[$];
  logic [23:0] seen[$];
  int          lat = 1;
  int          cyc = 0;
  int          xfers = 0;
  int          req_cycles = 0;
  logic        collect = 1'b0;

  logic [19:0] addr_m, line_m;
  int          y_m, remaining, gen;
  logic        exp_req, exp_uf;
  logic [23:0] exp_color;

  // Mid-cycle: check state left by the previous edge, drive the memory
  // response for the next edge, then advance the model across that edge.
  always @(negedge clk) begin : model
    logic        rv;
    logic [23:0] rd;
    int          rg;
    logic        xf, was_fetching;
    rv = 1'b0; rd = '0; rg = 0;
    mem_ack = 1'b1;
    if (rst) begin
      pend.delete(); mfifo.delete();
      addr_m = BASE; line_m = BASE; y_m = 0; remaining = 0; gen = 0;
      exp_req = 1'b0; exp_uf = 1'b0; exp_color = '0;
      mem_rvalid = 1'b0; mem_rdata = '0;
    end else begin
      chk("color_out", 32'(color_out), 32'(exp_color));
      chk("underflow", 32'(underflow), 32'(exp_uf));
      chk("fifo_level", 32'(fifo_level), 32'(mfifo.size()));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) chk("mem_addr", 32'(mem_addr), 32'(addr_m));
      if (collect && color_out != '0) seen.push_back(color_out);
      if (mem_req) req_cycles++;
      if (mem_req && mem_ack) xfers++;

      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rv = 1'b1; rd = {4'h0, pend[0].addr}; rg = pend[0].gen;
        pend.pop_front();
      end
      mem_rvalid = rv;
      mem_rdata  = rd;

      xf = exp_req && mem_ack;
      was_fetching = remaining > 0;
      if (active) begin
        if (mfifo.size() > 0) exp_color = mfifo.pop_front();
        else begin exp_color = UF_COLOR; exp_uf = 1'b1; end
      end else begin
        exp_color = '0;
      end
      if (rv && rg == gen && !frame_start) mfifo.push_back(rd);
      if (xf) begin
        pend.push_back('{addr: addr_m, due: cyc + lat, gen: gen});
        addr_m = addr_m + 20'd1;
        remaining--;
        if (remaining == 0) begin y_m++; line_m = line_m + 20'(H); end
      end
      if (frame_start) begin
        mfifo.delete(); y_m = 0; line_m = BASE; remaining = 0; gen++;
      end else if (line_start) begin
        if (was_fetching) exp_uf = 1'b1;
        else if (y_m < V) begin remaining = H; addr_m = line_m; end
      end
      exp_req = remaining > 0 && (mfifo.size() + pend.size()) < D;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic start_line();
    line_start = 1'b1; tick(); line_start = 1'b0;
  endtask

  task automatic chk_seq(input string nm, input logic [23:0] base, input logic [23:0] step, input int n);
    logic [23:0] e;
    chk({nm, "_count"}, 32'(seen.size()), 32'(n));
    e = base;
    for (int i = 0; i < n; i++) begin
      if (i < seen.size()) chk(nm, 32'(seen[i]), 32'(e));
      e = e + step;
    end
  endtask

  task automatic run_active(input int n);
    seen.delete(); collect = 1'b1; active = 1'b1;
    repeat (n) tick();
    active = 1'b0; repeat (2) tick(); collect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int x0, r0;
    rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; active = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_color", 32'(color_out), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h100);
    chk("rst_uf", 32'(underflow), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    rst = 1'b0; tick();

    // Line 0, latency 1
    pulse_fs(); start_line(); repeat (5) tick();
    run_active(8);
    chk_seq("line0_pix", 24'h100, 24'h1, 8);
    chk("line0_uf", 32'(underflow), 32'h0);

    // Line 1, latency 10: credit limit stops at 4 issued reads
    lat = 10; x0 = xfers;
    start_line(); repeat (30) tick();
    chk("credit_xfers", 32'(xfers - x0), 32'd4);
    chk("credit_level", 32'(fifo_level), 32'd4);
    seen.delete(); collect = 1'b1; active = 1'b1;
    repeat (4) tick();
    active = 1'b0; repeat (16) tick();
    active = 1'b1; repeat (4) tick();
    active = 1'b0; repeat (2) tick(); collect = 1'b0;
    chk_seq("line1_pix", 24'h108, 24'h1, 8);
    chk("line1_uf", 32'(underflow), 32'h0);

    // y == V: vertical blanking, no fetch
    r0 = req_cycles;
    start_line(); repeat (20) tick();
    chk("vblank_req", 32'(req_cycles - r0), 32'd0);

    // Underflow: active right after line_start with latency 10
    pulse_fs();
    line_start = 1'b1; tick(); line_start = 1'b0;
    seen.delete(); collect = 1'b1; active = 1'b1;
    repeat (8) tick();
    active = 1'b0; repeat (2) tick(); collect = 1'b0;
    chk_seq("uf_pix", UF_COLOR, 24'h0, 8);
    chk("uf_set", 32'(underflow), 32'h1);
    repeat (20) tick();
    chk("uf_sticky", 32'(underflow), 32'h1);

    // frame_start with 3 reads in flight
    pulse_fs(); x0 = xfers;
    start_line(); tick(); tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("fs_inflight", 32'(xfers - x0), 32'd3);
    chk("fs_req", 32'(mem_req), 32'h0);
    repeat (15) tick();
    chk("fs_level", 32'(fifo_level), 32'h0);
    lat = 1;
    start_line(); repeat (5) tick();
    run_active(8);
    chk_seq("fs_pix", 24'h100, 24'h1, 8);
    chk("fs_uf", 32'(underflow), 32'h1);

    // Asynchronous reset in the middle of a fetch
    start_line(); tick(); tick();
    active = 1'b1; tick(); active = 1'b0;
    chk("pre_rst_color", 32'(color_out), 32'h108);
    chk("pre_rst_req", 32'(mem_req), 32'h1);
    chk("pre_rst_level", 32'(fifo_level), 32'h1);
    rst = 1'b1; #1;
    chk("arst_color", 32'(color_out), 32'h0);
    chk("arst_req", 32'(mem_req), 32'h0);
    chk("arst_level", 32'(fifo_level), 32'h0);
    chk("arst_uf", 32'(underflow), 32'h0);
    tick(); rst = 1'b0; repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
